// File: rtl/piso8_serializer_pkg.sv
// Shared definitions for the serial blocks: byte width, bit-counter width and FSM encoding.
package piso8_serializer_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Mux select for the bit at position cnt; MSB-first walks the byte from the top (~cnt == 7-cnt).
  function automatic logic [CNT_W-1:0] bit_sel(input logic [CNT_W-1:0] cnt, input logic msb_first);
    return msb_first ? ~cnt : cnt;
  endfunction

endpackage

// File: rtl/piso8_serializer_if.sv
// Load-side and serial-side handshake bundle of the byte serializer.
interface piso8_serializer_if;
  import piso8_serializer_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [BYTE_W-1:0] data_in;
  logic              msb_first;
  logic              ser_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              busy;

  modport master (
    output load_valid, data_in, msb_first, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_valid, data_in, msb_first, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/piso8_serializer_mux8to1.sv
// Plain 8:1 bit multiplexer with select {s2,s1,s0}.
module mux8to1 (
  input  logic [7:0] d_i,
  input  logic       s2_i,
  input  logic       s1_i,
  input  logic       s0_i,
  output logic       y_o
);

  logic [2:0] sel;

  assign sel = {s2_i, s1_i, s0_i};
  assign y_o = d_i[sel];

endmodule

// File: rtl/piso8_serializer.sv
// Parallel-in/serial-out byte serializer with valid/ready on both sides and
// zero-gap back-to-back loading on the last-bit handshake.
module piso8_serializer
  import piso8_serializer_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  piso8_serializer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              msb_q, msb_d;

  logic             in_shift;
  logic             is_last;
  logic             load_hs;
  logic             bit_hs;
  logic [CNT_W-1:0] sel;
  logic             mux_y;

  assign in_shift = (state_q == SHIFT);
  assign is_last  = in_shift && (cnt_q == CNT_LAST);

  // A new byte may only enter when the register is empty or its last bit leaves this cycle.
  assign bus.load_ready = !in_shift || (bus.ser_ready && is_last);

  assign load_hs = bus.load_valid && bus.load_ready;
  assign bit_hs  = in_shift && bus.ser_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    msb_d   = msb_q;
    if (load_hs) begin
      state_d = SHIFT;
      cnt_d   = '0;
      byte_d  = bus.data_in;
      msb_d   = bus.msb_first;
    end else if (bit_hs) begin
      cnt_d = cnt_q + 1'b1;
      if (is_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      msb_q   <= msb_d;
    end
  end

  assign sel = bit_sel(cnt_q, msb_q);

  mux8to1 u_mux (
    .d_i  (byte_q),
    .s2_i (sel[2]),
    .s1_i (sel[1]),
    .s0_i (sel[0]),
    .y_o  (mux_y)
  );

  assign bus.ser_out   = in_shift ? mux_y : IDLE_LEVEL;
  assign bus.ser_valid = in_shift;
  assign bus.ser_last  = is_last;
  assign bus.busy      = in_shift;

endmodule

// File: doc/piso8_serializer.md
PISO8_SERIALIZER -- requirements
Module: piso8_serializer

Interface
REQ-001 Parameter IDLE_LEVEL, default 1'b0: level driven on ser_out when no bit is being presented.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 load_valid  input  1  upstream offers a parallel byte.
REQ-005 load_ready  output  1  block can accept a byte this cycle.
REQ-006 data_in  input  8  parallel byte; captured on load handshake only.
REQ-007 msb_first  input  1  bit order; captured together with data_in (1: bit7 first, 0: bit0 first).
REQ-008 ser_ready  input  1  downstream consumes the current bit this cycle.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out holds a valid bit.
REQ-011 ser_last  output  1  current bit is the eighth bit of the byte.
REQ-012 busy  output  1  high while in SHIFT.

Function
REQ-013 The FSM SHALL have two states, IDLE and SHIFT.
- IDLE -> SHIFT on load handshake (load_valid && load_ready).
- SHIFT -> IDLE on last-bit handshake (ser_valid && ser_ready && ser_last) with no new load.
- SHIFT -> SHIFT on a last-bit handshake coinciding with a load handshake.
REQ-014 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when ser_ready && ser_last; it SHALL be 0 otherwise.
REQ-015 On a load handshake the block SHALL register data_in and msb_first and clear the 3-bit bit counter to 0.
REQ-016 Latency: a byte accepted at edge N SHALL present its first bit with ser_valid=1 from the cycle after edge N.
REQ-017 In SHIFT, ser_valid SHALL be 1. ser_out SHALL equal byte[cnt] when msb_first=0 and byte[7-cnt] when msb_first=1, selected through an 8:1 mux with select {s2,s1,s0} = cnt or ~cnt.
REQ-018 Each bit SHALL be held stable, together with ser_last, until the cycle in which ser_ready=1. On that edge cnt SHALL increment by 1, modulo 8.
REQ-019 ser_last SHALL be 1 only when in SHIFT and cnt==7.
REQ-020 Wrap-around: cnt 7 -> 0 at the last-bit handshake. With a concurrent load, the new byte's first bit SHALL appear in the next cycle with no idle gap.
REQ-021 In IDLE: ser_valid=0, ser_last=0, ser_out=IDLE_LEVEL, and ser_ready SHALL be ignored.
REQ-022 load_valid asserted while load_ready=0 SHALL have no effect. data_in SHALL NOT be re-sampled while in SHIFT.
REQ-023 busy SHALL be 1 exactly when the state is SHIFT.

Reset
REQ-024 When rst=1 at an edge, state SHALL become IDLE and cnt and the byte register SHALL clear to 0. Any byte in progress SHALL be discarded.
REQ-025 Reset output values: load_ready=1, ser_valid=0, ser_last=0, busy=0, ser_out=IDLE_LEVEL.
REQ-026 rst SHALL take priority over a simultaneous load or shift handshake.

Structure
REQ-027 State encodings (IDLE=1'b0, SHIFT=1'b1) and the byte width constant (8) SHALL live in a shared package/header for serial blocks.
REQ-028 The bit-select datapath SHALL instantiate the existing mux8to1 module as its single sub-module. All other logic SHALL be local.

Verification
REQ-029 Load 8'hA5 with msb_first=0 and ser_ready held 1 -> ser_out over 8 cycles = 1,0,1,0,0,1,0,1; ser_last only on the 8th cycle; then IDLE.
REQ-030 Load 8'hA5 with msb_first=1 -> sequence 1,0,1,0,0,1,0,1 (symmetric pattern). Load 8'h80 with msb_first=1 -> 1 followed by seven 0s.
REQ-031 Backpressure: load 8'h0F, hold ser_ready=0 for 3 cycles on bit 2 -> ser_out stays 1 and cnt is unchanged until ser_ready returns. Total bits seen = 8.
REQ-032 Back-to-back: present 8'hFF, then 8'h00 with load_valid held -> 16 consecutive valid bits (8 ones, then 8 zeros) with no ser_valid gap; load_ready=1 only on the cycles with ser_last=1 and in the initial IDLE.
REQ-033 Reset mid-operation: assert rst after 3 bits of 8'h3C -> next cycle ser_valid=0, busy=0, load_ready=1, ser_out=IDLE_LEVEL; a new load of 8'h01 then serializes correctly starting from bit 0.
REQ-034 In IDLE, toggling ser_ready and holding load_valid=0 for 10 cycles -> no output change.
